// File: rtl/yutorina_spm_pipe_pkg.sv
// Shared constants and types for the scratch-pad memory: default geometry,
// clear-engine state encoding and the active-low strobe / access-direction
// encodings used on the CPU side of the SPM.
package yutorina_spm_pipe_pkg;

    // Default word width in bits; must be a multiple of 8.
    localparam int SPM_WORD_W = 32;
    // Default word-address width; depth is 2**SPM_ADDR_W words.
    localparam int SPM_ADDR_W = 12;

    // Number of byte lanes in a word of the given width.
    function automatic int spm_be_w(input int word_w);
        return word_w / 8;
    endfunction

    // Default byte-enable width.
    localparam int SPM_BE_W = spm_be_w(SPM_WORD_W);

    // Access direction on the data port.
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    // Active-low strobe levels.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Clear engine: CLEAR zeroes the array after reset, RUN serves the CPU.
    typedef enum logic {
        SPM_ST_CLEAR = 1'b0,
        SPM_ST_RUN   = 1'b1
    } spm_state_e;

endpackage

// File: rtl/yutorina_spm_pipe_if.sv
// CPU-side bundle of the scratch-pad memory: the read-only instruction port,
// the read/write data port and the clear-engine busy flag.
// master = CPU (IF/MEM stages), slave = SPM.
interface yutorina_spm_pipe_if
    import yutorina_spm_pipe_pkg::*;
#(
    parameter int WORD_W = SPM_WORD_W,
    parameter int ADDR_W = SPM_ADDR_W
);
    localparam int BE_W = spm_be_w(WORD_W);

    // Instruction port
    logic [ADDR_W-1:0] i_addr;
    logic              i_as_;
    logic [WORD_W-1:0] i_r_data;
    logic              i_rdy_;

    // Data port
    logic [ADDR_W-1:0] d_addr;
    logic              d_as_;
    logic              d_rw;
    logic [BE_W-1:0]   d_be;
    logic [WORD_W-1:0] d_w_data;
    logic [WORD_W-1:0] d_r_data;
    logic              d_rdy_;

    // Clear engine status
    logic              init_busy;

    modport master (
        output i_addr, i_as_,
        output d_addr, d_as_, d_rw, d_be, d_w_data,
        input  i_r_data, i_rdy_,
        input  d_r_data, d_rdy_,
        input  init_busy
    );

    modport slave (
        input  i_addr, i_as_,
        input  d_addr, d_as_, d_rw, d_be, d_w_data,
        output i_r_data, i_rdy_,
        output d_r_data, d_rdy_,
        output init_busy
    );

endinterface

// File: rtl/yutorina_spm_bram.sv
// Inferred true dual-port RAM, split into one byte-wide array per lane so the
// per-byte write enable on port B maps onto independent lane memories.
// Port A: read-only, read-first against a same-cycle port B write.
// Port B: read/write, write-first (returns the merged word on a write).
// Both ports have a one-cycle registered read that holds while not enabled.
module yutorina_spm_bram
    import yutorina_spm_pipe_pkg::*;
#(
    parameter int WORD_W = SPM_WORD_W,
    parameter int ADDR_W = SPM_ADDR_W
) (
    input  logic                       clk,
    input  logic                       srst,
    // Port A
    input  logic                       a_en,
    input  logic [ADDR_W-1:0]          a_addr,
    output logic [WORD_W-1:0]          a_r_data,
    // Port B
    input  logic                       b_en,
    input  logic                       b_we,
    input  logic [spm_be_w(WORD_W)-1:0] b_be,
    input  logic [ADDR_W-1:0]          b_addr,
    input  logic [WORD_W-1:0]          b_w_data,
    output logic [WORD_W-1:0]          b_r_data
);
    localparam int BE_W  = spm_be_w(WORD_W);
    localparam int DEPTH = 1 << ADDR_W;

    for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] a_q_reg;
        logic [7:0] b_q_reg;
        logic       lane_we;

        assign lane_we = b_en && b_we && b_be[gi];

        // Lane storage: port B writes this byte when its enable bit is set.
        always_ff @(posedge clk) begin
            if (lane_we) begin
                mem[b_addr] <= b_w_data[gi*8 +: 8];
            end
        end

        // Port A registered read; sees the pre-write contents on a collision.
        always_ff @(posedge clk) begin
            if (srst) begin
                a_q_reg <= '0;
            end else if (a_en) begin
                a_q_reg <= mem[a_addr];
            end
        end

        // Port B registered read; a written byte is returned as new data.
        always_ff @(posedge clk) begin
            if (srst) begin
                b_q_reg <= '0;
            end else if (b_en) begin
                b_q_reg <= lane_we ? b_w_data[gi*8 +: 8] : mem[b_addr];
            end
        end

        assign a_r_data[gi*8 +: 8] = a_q_reg;
        assign b_r_data[gi*8 +: 8] = b_q_reg;
    end

endmodule

// File: rtl/yutorina_spm_pipe.sv
// Scratch-pad memory top: post-reset clear engine, port B address/data mux
// between the clear engine and the CPU data port, ready-strobe valid pipeline
// and an optional output register stage (read latency 1 or 2 cycles).
module yutorina_spm_pipe
    import yutorina_spm_pipe_pkg::*;
#(
    parameter int WORD_W         = SPM_WORD_W,
    parameter int ADDR_W         = SPM_ADDR_W,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset_,
    yutorina_spm_pipe_if.slave bus
);
    localparam int BE_W = spm_be_w(WORD_W);

    spm_state_e        state_reg;
    spm_state_e        state_next;
    logic [ADDR_W-1:0] clr_cnt_reg;
    logic [ADDR_W-1:0] clr_cnt_next;
    logic              clearing;

    logic              srst;
    logic              running;
    logic              i_req;
    logic              d_req;

    logic              b_en;
    logic              b_we;
    logic [BE_W-1:0]   b_be;
    logic [ADDR_W-1:0] b_addr;
    logic [WORD_W-1:0] b_w_data;
    logic [WORD_W-1:0] a_r_data;
    logic [WORD_W-1:0] b_r_data;

    assign srst = ~reset_;

    // Clear-engine state and address counter; reset restarts at address 0.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_reg   <= (CLEAR_ON_RESET != 0) ? SPM_ST_CLEAR : SPM_ST_RUN;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    // Next state: one word zeroed per cycle, RUN after the last address.
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        clearing     = 1'b0;
        case (state_reg)
            SPM_ST_CLEAR: begin
                clearing     = 1'b1;
                clr_cnt_next = clr_cnt_reg + ADDR_W'(1);
                if (clr_cnt_reg == '1) begin
                    state_next = SPM_ST_RUN;
                end
            end
            SPM_ST_RUN: begin
                state_next = SPM_ST_RUN;
            end
            default: begin
                state_next = SPM_ST_RUN;
            end
        endcase
    end

    // Requests are taken only in RUN and never on a reset edge.
    assign running = (state_reg == SPM_ST_RUN);
    assign i_req   = running && reset_ && (bus.i_as_ == ENABLE_);
    assign d_req   = running && reset_ && (bus.d_as_ == ENABLE_);

    assign bus.init_busy = (state_reg == SPM_ST_CLEAR);

    // Port B is owned by the clear engine while clearing, else by the CPU.
    always_comb begin
        b_en     = 1'b0;
        b_we     = 1'b0;
        b_be     = '0;
        b_addr   = bus.d_addr;
        b_w_data = bus.d_w_data;
        if (clearing) begin
            b_en     = 1'b1;
            b_we     = 1'b1;
            b_be     = '1;
            b_addr   = clr_cnt_reg;
            b_w_data = '0;
        end else if (d_req) begin
            b_en     = 1'b1;
            b_we     = (bus.d_rw == WRITE);
            b_be     = bus.d_be;
        end
    end

    yutorina_spm_bram #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_bram (
        .clk      (clk),
        .srst     (srst),
        .a_en     (i_req),
        .a_addr   (bus.i_addr),
        .a_r_data (a_r_data),
        .b_en     (b_en),
        .b_we     (b_we),
        .b_be     (b_be),
        .b_addr   (b_addr),
        .b_w_data (b_w_data),
        .b_r_data (b_r_data)
    );

    if (OUT_REG != 0) begin : g_out_reg
        logic [1:0]        i_vld_reg;
        logic [1:0]        d_vld_reg;
        logic [WORD_W-1:0] i_q_reg;
        logic [WORD_W-1:0] d_q_reg;

        // Two-stage valid pipeline plus output registers loaded behind the RAM.
        always_ff @(posedge clk) begin
            if (!reset_) begin
                i_vld_reg <= '0;
                d_vld_reg <= '0;
                i_q_reg   <= '0;
                d_q_reg   <= '0;
            end else begin
                i_vld_reg <= {i_vld_reg[0], i_req};
                d_vld_reg <= {d_vld_reg[0], d_req};
                if (i_vld_reg[0]) begin
                    i_q_reg <= a_r_data;
                end
                if (d_vld_reg[0]) begin
                    d_q_reg <= b_r_data;
                end
            end
        end

        assign bus.i_r_data = i_q_reg;
        assign bus.d_r_data = d_q_reg;
        assign bus.i_rdy_   = i_vld_reg[1] ? ENABLE_ : DISABLE_;
        assign bus.d_rdy_   = d_vld_reg[1] ? ENABLE_ : DISABLE_;
    end else begin : g_no_out_reg
        logic i_vld_reg;
        logic d_vld_reg;

        // Single-stage valid pipeline aligned with the RAM registered read.
        always_ff @(posedge clk) begin
            if (!reset_) begin
                i_vld_reg <= 1'b0;
                d_vld_reg <= 1'b0;
            end else begin
                i_vld_reg <= i_req;
                d_vld_reg <= d_req;
            end
        end

        assign bus.i_r_data = a_r_data;
        assign bus.d_r_data = b_r_data;
        assign bus.i_rdy_   = i_vld_reg ? ENABLE_ : DISABLE_;
        assign bus.d_rdy_   = d_vld_reg ? ENABLE_ : DISABLE_;
    end

endmodule

// File: tb/tb_yutorina_spm_pipe.sv
// Bench for yutorina_spm_pipe: two instances (OUT_REG=0 and OUT_REG=1, both
// ADDR_W=4 with clear on reset) receive identical stimulus. Expected read data
// comes from a byte-enable-aware memory model and is queued per port with the
// cycle it must appear; a negedge monitor compares rdy_ and data every cycle.
module tb_yutorina_spm_pipe;
    import yutorina_spm_pipe_pkg::*;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int WW    = 32;

    logic clk = 1'b0;
    logic reset_ = 1'b0;
    always #5 clk = ~clk;

    yutorina_spm_pipe_if #(.WORD_W(WW), .ADDR_W(AW)) bus0 ();
    yutorina_spm_pipe_if #(.WORD_W(WW), .ADDR_W(AW)) bus1 ();

    yutorina_spm_pipe #(.WORD_W(WW), .ADDR_W(AW), .OUT_REG(0), .CLEAR_ON_RESET(1)) dut0 (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus0.slave)
    );

    yutorina_spm_pipe #(.WORD_W(WW), .ADDR_W(AW), .OUT_REG(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus1.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t iq0[$];
    exp_t dq0[$];
    exp_t iq1[$];
    exp_t dq1[$];

    logic [31:0] mem_model [DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One port of one instance: a pulse with data is due this cycle, or rdy_ stays high.
    task automatic mon(input string tag, input logic rdy, input logic [31:0] data,
                       input bit have, input int due, input logic [31:0] exp, output bit pop);
        pop = 1'b0;
        if (have && due == cyc) begin
            check({tag, "_rdy"}, {31'd0, rdy}, 32'd0);
            check({tag, "_data"}, data, exp);
            pop = 1'b1;
        end else begin
            check({tag, "_idle_rdy"}, {31'd0, rdy}, 32'd1);
        end
    endtask

    always @(negedge clk) begin
        bit p;
        if (mon_en) begin
            mon("i0", bus0.i_rdy_, bus0.i_r_data, iq0.size() != 0,
                iq0.size() != 0 ? iq0[0].due : -1, iq0.size() != 0 ? iq0[0].data : 32'd0, p);
            if (p) void'(iq0.pop_front());
            mon("d0", bus0.d_rdy_, bus0.d_r_data, dq0.size() != 0,
                dq0.size() != 0 ? dq0[0].due : -1, dq0.size() != 0 ? dq0[0].data : 32'd0, p);
            if (p) void'(dq0.pop_front());
            mon("i1", bus1.i_rdy_, bus1.i_r_data, iq1.size() != 0,
                iq1.size() != 0 ? iq1[0].due : -1, iq1.size() != 0 ? iq1[0].data : 32'd0, p);
            if (p) void'(iq1.pop_front());
            mon("d1", bus1.d_rdy_, bus1.d_r_data, dq1.size() != 0,
                dq1.size() != 0 ? dq1[0].due : -1, dq1.size() != 0 ? dq1[0].data : 32'd0, p);
            if (p) void'(dq1.pop_front());
        end
    end

    // Drive one cycle of stimulus on both instances and queue the expected results.
    task automatic drive(input bit i_en, input int i_a, input bit d_en, input logic rw,
                         input int d_a, input logic [3:0] be, input logic [31:0] wd);
        exp_t        e;
        logic [31:0] merged;
        @(posedge clk);
        #1;
        bus0.i_as_ = i_en ? ENABLE_ : DISABLE_;  bus1.i_as_ = bus0.i_as_;
        bus0.i_addr = AW'(i_a);                  bus1.i_addr = bus0.i_addr;
        bus0.d_as_ = d_en ? ENABLE_ : DISABLE_;  bus1.d_as_ = bus0.d_as_;
        bus0.d_rw = rw;                          bus1.d_rw = rw;
        bus0.d_addr = AW'(d_a);                  bus1.d_addr = bus0.d_addr;
        bus0.d_be = be;                          bus1.d_be = be;
        bus0.d_w_data = wd;                      bus1.d_w_data = wd;
        if (i_en) begin
            e.data = mem_model[i_a];
            e.due = cyc + 1; iq0.push_back(e);
            e.due = cyc + 2; iq1.push_back(e);
            $display("txn i read  addr=%0d expect=%h", i_a, e.data);
        end
        if (d_en) begin
            if (rw == READ) begin
                e.data = mem_model[d_a];
                $display("txn d read  addr=%0d expect=%h", d_a, e.data);
            end else begin
                merged = mem_model[d_a];
                for (int k = 0; k < 4; k++) begin
                    if (be[k]) merged[k*8 +: 8] = wd[k*8 +: 8];
                end
                mem_model[d_a] = merged;
                e.data = merged;
                $display("txn d write addr=%0d be=%b data=%h expect=%h", d_a, be, wd, merged);
            end
            e.due = cyc + 1; dq0.push_back(e);
            e.due = cyc + 2; dq1.push_back(e);
        end
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, READ, 0, 4'h0, 32'h0);
    endtask

    // Count cycles with init_busy high on each instance, bounded.
    task automatic wait_clear(output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus0.init_busy) c0++;
            if (bus1.init_busy) c1++;
            if (!bus0.init_busy && !bus1.init_busy) break;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_i_data0"}, bus0.i_r_data, 32'd0);
        check({tag, "_d_data0"}, bus0.d_r_data, 32'd0);
        check({tag, "_i_rdy0"}, {31'd0, bus0.i_rdy_}, 32'd1);
        check({tag, "_d_rdy0"}, {31'd0, bus0.d_rdy_}, 32'd1);
        check({tag, "_busy0"}, {31'd0, bus0.init_busy}, 32'd1);
        check({tag, "_i_data1"}, bus1.i_r_data, 32'd0);
        check({tag, "_d_data1"}, bus1.d_r_data, 32'd0);
        check({tag, "_i_rdy1"}, {31'd0, bus1.i_rdy_}, 32'd1);
        check({tag, "_d_rdy1"}, {31'd0, bus1.d_rdy_}, 32'd1);
        check({tag, "_busy1"}, {31'd0, bus1.init_busy}, 32'd1);
    endtask

    initial begin
        int c0;
        int c1;
        bus0.i_as_ = DISABLE_; bus1.i_as_ = DISABLE_;
        bus0.d_as_ = DISABLE_; bus1.d_as_ = DISABLE_;
        bus0.i_addr = '0; bus1.i_addr = '0;
        bus0.d_addr = '0; bus1.d_addr = '0;
        bus0.d_rw = READ; bus1.d_rw = READ;
        bus0.d_be = '0; bus1.d_be = '0;
        bus0.d_w_data = '0; bus1.d_w_data = '0;

        // Power-on reset, then the full clear must take exactly DEPTH cycles.
        reset_ = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        mon_en = 1'b1;
        reset_ = 1'b1;
        wait_clear(c0, c1);
        check("clear_len0", c0, DEPTH);
        check("clear_len1", c1, DEPTH);
        for (int a = 0; a < DEPTH; a++) mem_model[a] = 32'd0;

        // Every word reads back zero after the clear, on both ports.
        for (int a = 0; a < DEPTH; a++) drive(1'b1, a, 1'b1, READ, DEPTH - 1 - a, 4'h0, 32'h0);

        // Full-word write, single-byte merge, read back.
        drive(1'b0, 0, 1'b1, WRITE, 3, 4'b1111, 32'hDEADBEEF);
        drive(1'b0, 0, 1'b1, WRITE, 3, 4'b0001, 32'h000000AA);
        drive(1'b0, 0, 1'b1, READ, 3, 4'h0, 32'h0);

        // All-zero byte enables acknowledge but change nothing.
        drive(1'b0, 0, 1'b1, WRITE, 2, 4'b1111, 32'h11111111);
        drive(1'b0, 0, 1'b1, WRITE, 2, 4'b0000, 32'hFFFFFFFF);
        drive(1'b1, 2, 1'b1, READ, 2, 4'h0, 32'h0);

        // Same-address collision: port A read-first, port B write-first.
        drive(1'b1, 5, 1'b1, WRITE, 5, 4'b1111, 32'h12345678);
        drive(1'b1, 5, 1'b0, READ, 0, 4'h0, 32'h0);

        // Back-to-back reads on both ports, one per cycle.
        for (int a = 0; a < 8; a++) drive(1'b1, a, 1'b1, READ, a, 4'h0, 32'h0);
        idle();
        idle();

        // Reset with reads in flight: the 2-stage instance loses its pulses.
        drive(1'b1, 5, 1'b1, READ, 3, 4'h0, 32'h0);
        @(posedge clk);
        #1;
        bus0.i_as_ = DISABLE_; bus1.i_as_ = DISABLE_;
        bus0.d_as_ = DISABLE_; bus1.d_as_ = DISABLE_;
        reset_ = 1'b0;
        iq1.delete();
        dq1.delete();
        @(posedge clk);
        #1;
        reset_ = 1'b1;
        check_reset_vals("inflight");

        // Reset again while the clear is at address 9: it restarts from 0.
        repeat (9) @(posedge clk);
        #1;
        check("midclear_busy0", {31'd0, bus0.init_busy}, 32'd1);
        check("midclear_busy1", {31'd0, bus1.init_busy}, 32'd1);
        reset_ = 1'b0;
        @(posedge clk);
        #1;
        reset_ = 1'b1;
        wait_clear(c0, c1);
        check("restart_len0", c0, DEPTH);
        check("restart_len1", c1, DEPTH);
        for (int a = 0; a < DEPTH; a++) mem_model[a] = 32'd0;

        // Previously written words are zero again.
        drive(1'b1, 3, 1'b1, READ, 5, 4'h0, 32'h0);
        drive(1'b1, 2, 1'b1, READ, 3, 4'h0, 32'h0);
        repeat (4) idle();

        check("drain", iq0.size() + dq0.size() + iq1.size() + dq1.size(), 32'd0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
